// File: rtl/decode_pipe_reg_hz.sv
// ---------------------------------------------------------------------------
// decode_pipe_reg_hz
//
// Decode stage with the D->E pipeline register. It contains:
//   - a 16-entry register file with write-through bypass from writeback
//   - operand selection (immediate / store data / return-address read)
//   - load-use interlock detection and the fetch stall
//   - the D->E register with valid bit, hold, bubble and flush
//   - a saturating count of load-use bubbles
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   valid_D, pc_D, instruction_D, imm_D, branch_target_D, ctrl_D,
//   is_*_D, use_rs1_D, use_rs2_D
//                              decode-stage instruction and decoded control
//   wb_en, wb_reg, wb_data     writeback port into the register file
//   flush_E                    branch taken in execute, kill the D->E transfer
//   hold_E                     downstream stall, freeze the D->E register
//   stall_F                    fetch/decode must hold the current instruction
//   valid_E, pc_E, ... rd_E    registered execute-stage view of the instruction
//   stall_cnt                  saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module decode_pipe_reg_hz #(
  parameter int          DATA_W    = 32,
  parameter int          CTRL_W    = 12,
  parameter int          RA_REG    = 15,
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              valid_D,
  input  logic [DATA_W-1:0] pc_D,
  input  logic [31:0]       instruction_D,
  input  logic [DATA_W-1:0] imm_D,
  input  logic [DATA_W-1:0] branch_target_D,
  input  logic              is_st_D,
  input  logic              is_ret_D,
  input  logic              is_imm_D,
  input  logic              is_ld_D,
  input  logic              is_wb_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [CTRL_W-1:0] ctrl_D,

  input  logic              wb_en,
  input  logic [3:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,

  input  logic              flush_E,
  input  logic              hold_E,

  output logic              stall_F,
  output logic              valid_E,
  output logic [DATA_W-1:0] pc_E,
  output logic [DATA_W-1:0] branch_target_E,
  output logic [DATA_W-1:0] a_E,
  output logic [DATA_W-1:0] b_E,
  output logic [DATA_W-1:0] rd2_E,
  output logic [31:0]       instr_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic              is_st_E,
  output logic              is_ret_E,
  output logic              is_imm_E,
  output logic              is_ld_E,
  output logic              is_wb_E,
  output logic [3:0]        rs1_E,
  output logic [3:0]        rs2_E,
  output logic [3:0]        rd_E,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [3:0]       RA_IDX  = RA_REG[3:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Register file: not reset, and written regardless of rst/flush/hold.
  logic [DATA_W-1:0] rf [16];

  always_ff @(posedge clk) begin
    if (wb_en) begin
      rf[wb_reg] <= wb_data;
    end
  end

  // Read addresses. A return reads the link register on port 1; a store
  // reads its data register (the rd field) on port 2.
  logic [3:0] ra1;
  logic [3:0] ra2;
  logic [3:0] rd_D;

  always_comb begin
    ra1  = is_ret_D ? RA_IDX : instruction_D[21:18];
    ra2  = is_st_D ? instruction_D[25:22] : instruction_D[17:14];
    rd_D = instruction_D[25:22];
  end

  // Write-through bypass: a same-cycle write is visible to the read.
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] b_D;

  always_comb begin
    rd1 = (wb_en && (wb_reg == ra1)) ? wb_data : rf[ra1];
    rd2 = (wb_en && (wb_reg == ra2)) ? wb_data : rf[ra2];
    b_D = is_imm_D ? imm_D : rd2;
  end

  // Load-use interlock: the load in E has not produced its data yet, so a
  // dependent instruction in D must wait one cycle. A flush makes the
  // dependency moot, so it does not stall fetch by itself.
  logic lu;

  always_comb begin
    lu = valid_D && valid_E && is_ld_E &&
         ((use_rs1_D && (rd_E == ra1)) || (use_rs2_D && (rd_E == ra2)));
    stall_F = hold_E || (lu && !flush_E);
  end

  // D->E update priority: rst, flush, hold, load-use, empty D, capture.
  logic load_bubble;
  logic load_capture;
  logic count_lu;

  always_comb begin
    load_bubble  = 1'b0;
    load_capture = 1'b0;
    count_lu     = 1'b0;
    if (rst || flush_E) begin
      load_bubble = 1'b1;
    end else if (hold_E) begin
      load_bubble = 1'b0;
    end else if (lu) begin
      load_bubble = 1'b1;
      count_lu    = 1'b1;
    end else if (!valid_D) begin
      load_bubble = 1'b1;
    end else begin
      load_capture = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      valid_E         <= 1'b0;
      pc_E            <= '0;
      branch_target_E <= '0;
      a_E             <= '0;
      b_E             <= '0;
      rd2_E           <= '0;
      instr_E         <= NOP_INSTR;
      ctrl_E          <= '0;
      is_st_E         <= 1'b0;
      is_ret_E        <= 1'b0;
      is_imm_E        <= 1'b0;
      is_ld_E         <= 1'b0;
      is_wb_E         <= 1'b0;
      rs1_E           <= 4'd0;
      rs2_E           <= 4'd0;
      rd_E            <= 4'd0;
    end else if (load_capture) begin
      valid_E         <= 1'b1;
      pc_E            <= pc_D;
      branch_target_E <= branch_target_D;
      a_E             <= rd1;
      b_E             <= b_D;
      rd2_E           <= rd2;
      instr_E         <= instruction_D;
      ctrl_E          <= ctrl_D;
      is_st_E         <= is_st_D;
      is_ret_E        <= is_ret_D;
      is_imm_E        <= is_imm_D;
      is_ld_E         <= is_ld_D;
      is_wb_E         <= is_wb_D;
      // Effective read addresses, so E-stage forwarding sees what was read.
      rs1_E           <= ra1;
      rs2_E           <= ra2;
      rd_E            <= rd_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (count_lu && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_pipe_reg_hz.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_reg_hz
//
// Scoreboard bench. Each cycle the driver applies one set of decode inputs,
// predicts the E-stage contents from the pipeline rules and queues them; a
// monitor pops one expectation after every rising edge and compares.
// stall_F is combinational and is checked by the driver in the same cycle.
// The counter is built 3 bits wide so saturation is reached.
// ---------------------------------------------------------------------------
module tb_decode_pipe_reg_hz;

  localparam int          CNT_W = 3;
  localparam logic [31:0] NOP   = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_D;
  logic [31:0] pc_D, instruction_D, imm_D, branch_target_D;
  logic        is_st_D, is_ret_D, is_imm_D, is_ld_D, is_wb_D;
  logic        use_rs1_D, use_rs2_D;
  logic [11:0] ctrl_D;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush_E, hold_E;
  logic        stall_F, valid_E;
  logic [31:0] pc_E, branch_target_E, a_E, b_E, rd2_E, instr_E;
  logic [11:0] ctrl_E;
  logic        is_st_E, is_ret_E, is_imm_E, is_ld_E, is_wb_E;
  logic [3:0]  rs1_E, rs2_E, rd_E;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_pipe_reg_hz #(.DATA_W(32), .CTRL_W(12), .RA_REG(15),
                       .NOP_INSTR(32'h6800_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .pc_D(pc_D),
    .instruction_D(instruction_D), .imm_D(imm_D),
    .branch_target_D(branch_target_D), .is_st_D(is_st_D),
    .is_ret_D(is_ret_D), .is_imm_D(is_imm_D), .is_ld_D(is_ld_D),
    .is_wb_D(is_wb_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .ctrl_D(ctrl_D), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush_E(flush_E), .hold_E(hold_E), .stall_F(stall_F),
    .valid_E(valid_E), .pc_E(pc_E), .branch_target_E(branch_target_E),
    .a_E(a_E), .b_E(b_E), .rd2_E(rd2_E), .instr_E(instr_E),
    .ctrl_E(ctrl_E), .is_st_E(is_st_E), .is_ret_E(is_ret_E),
    .is_imm_E(is_imm_E), .is_ld_E(is_ld_E), .is_wb_E(is_wb_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        rst, valid;
    logic [31:0] pc, instr, imm, bt;
    logic        st, ret, imm_sel, ld, wb;
    logic        use1, use2;
    logic [11:0] ctrl;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        flush, hold;
  } drv_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, bt, a, b, rd2, instr;
    logic [11:0] ctrl;
    logic        st, ret, imm_sel, ld, wb;
    logic [3:0]  rs1, rs2, rd;
    int          cnt;
  } exp_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q[$];
  exp_t m_e;
  logic [31:0] m_rf [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t bubble(input int cnt);
    exp_t e;
    e.valid = 1'b0; e.pc = '0; e.bt = '0; e.a = '0; e.b = '0; e.rd2 = '0;
    e.instr = NOP; e.ctrl = '0; e.st = 1'b0; e.ret = 1'b0; e.imm_sel = 1'b0;
    e.ld = 1'b0; e.wb = 1'b0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.cnt = cnt;
    return e;
  endfunction

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = $urandom;
    w[25:22] = rd[3:0];
    w[21:18] = rs1[3:0];
    w[17:14] = rs2[3:0];
    return w;
  endfunction

  function automatic drv_t idle();
    drv_t d;
    d.rst = 1'b0; d.valid = 1'b0; d.pc = '0; d.instr = '0; d.imm = '0;
    d.bt = '0; d.st = 1'b0; d.ret = 1'b0; d.imm_sel = 1'b0; d.ld = 1'b0;
    d.wb = 1'b0; d.use1 = 1'b0; d.use2 = 1'b0; d.ctrl = '0; d.wb_en = 1'b0;
    d.wb_reg = '0; d.wb_data = '0; d.flush = 1'b0; d.hold = 1'b0;
    return d;
  endfunction

  function automatic drv_t instr_d(input int rd, input int rs1, input int rs2);
    drv_t d = idle();
    d.valid = 1'b1; d.instr = mk(rd, rs1, rs2);
    d.pc = $urandom; d.bt = $urandom; d.imm = $urandom; d.ctrl = 12'($urandom);
    d.use1 = 1'b1; d.use2 = 1'b1; d.wb = 1'b1;
    return d;
  endfunction

  function automatic drv_t rnd();
    drv_t d = instr_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    d.valid   = ($urandom_range(0, 7) != 0);
    d.st      = ($urandom_range(0, 4) == 0);
    d.ret     = ($urandom_range(0, 6) == 0);
    d.imm_sel = ($urandom_range(0, 2) == 0);
    d.ld      = ($urandom_range(0, 1) == 0);
    d.wb      = 1'($urandom);
    d.use1    = ($urandom_range(0, 3) != 0);
    d.use2    = ($urandom_range(0, 2) != 0);
    d.wb_en   = 1'($urandom);
    d.wb_reg  = 4'($urandom);
    d.wb_data = $urandom;
    d.flush   = ($urandom_range(0, 9) == 0);
    d.hold    = ($urandom_range(0, 7) == 0);
    d.rst     = ($urandom_range(0, 99) == 0);
    return d;
  endfunction

  // Apply one cycle of inputs, check stall_F, predict the next E contents.
  task automatic step(input drv_t d);
    logic [3:0]  ra1, ra2;
    logic [31:0] v1, v2;
    logic        lu, sf;
    exp_t        nx;
    @(negedge clk);
    rst = d.rst; valid_D = d.valid; pc_D = d.pc; instruction_D = d.instr;
    imm_D = d.imm; branch_target_D = d.bt; is_st_D = d.st; is_ret_D = d.ret;
    is_imm_D = d.imm_sel; is_ld_D = d.ld; is_wb_D = d.wb;
    use_rs1_D = d.use1; use_rs2_D = d.use2; ctrl_D = d.ctrl;
    wb_en = d.wb_en; wb_reg = d.wb_reg; wb_data = d.wb_data;
    flush_E = d.flush; hold_E = d.hold;
    #1;
    ra1 = d.ret ? 4'd15 : d.instr[21:18];
    ra2 = d.st ? d.instr[25:22] : d.instr[17:14];
    v1  = (d.wb_en && d.wb_reg == ra1) ? d.wb_data : m_rf[ra1];
    v2  = (d.wb_en && d.wb_reg == ra2) ? d.wb_data : m_rf[ra2];
    lu  = d.valid && m_e.valid && m_e.ld &&
          ((d.use1 && m_e.rd == ra1) || (d.use2 && m_e.rd == ra2));
    sf  = d.hold || (lu && !d.flush);
    chk("stall_F", {63'd0, stall_F}, {63'd0, sf});
    if (d.rst)        nx = bubble(0);
    else if (d.flush) nx = bubble(m_e.cnt);
    else if (d.hold)  nx = m_e;
    else if (lu)      nx = bubble((m_e.cnt < 2**CNT_W - 1) ? m_e.cnt + 1 : m_e.cnt);
    else if (!d.valid) nx = bubble(m_e.cnt);
    else begin
      nx.valid = 1'b1; nx.pc = d.pc; nx.bt = d.bt; nx.a = v1;
      nx.b = d.imm_sel ? d.imm : v2; nx.rd2 = v2; nx.instr = d.instr;
      nx.ctrl = d.ctrl; nx.st = d.st; nx.ret = d.ret; nx.imm_sel = d.imm_sel;
      nx.ld = d.ld; nx.wb = d.wb; nx.rs1 = ra1; nx.rs2 = ra2;
      nx.rd = d.instr[25:22]; nx.cnt = m_e.cnt;
    end
    q.push_back(nx);
    m_e = nx;
    if (d.wb_en) m_rf[d.wb_reg] = d.wb_data;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("valid_E", {63'd0, valid_E}, {63'd0, e.valid});
      chk("pc_E", {32'd0, pc_E}, {32'd0, e.pc});
      chk("branch_target_E", {32'd0, branch_target_E}, {32'd0, e.bt});
      chk("a_E", {32'd0, a_E}, {32'd0, e.a});
      chk("b_E", {32'd0, b_E}, {32'd0, e.b});
      chk("rd2_E", {32'd0, rd2_E}, {32'd0, e.rd2});
      chk("instr_E", {32'd0, instr_E}, {32'd0, e.instr});
      chk("ctrl_E", {52'd0, ctrl_E}, {52'd0, e.ctrl});
      chk("is_flags_E", {59'd0, is_st_E, is_ret_E, is_imm_E, is_ld_E, is_wb_E},
          {59'd0, e.st, e.ret, e.imm_sel, e.ld, e.wb});
      chk("regidx_E", {52'd0, rs1_E, rs2_E, rd_E}, {52'd0, e.rs1, e.rs2, e.rd});
      chk("stall_cnt", {{(64-CNT_W){1'b0}}, stall_cnt}, 64'(e.cnt));
    end
  end

  initial begin
    drv_t d;
    m_e = bubble(0);
    for (int i = 0; i < 16; i++) m_rf[i] = 'x;

    // Reset with the register file initialised through writeback.
    for (int i = 0; i < 16; i++) begin
      d = idle(); d.rst = 1'b1; d.wb_en = 1'b1; d.wb_reg = 4'(i);
      d.wb_data = (i == 15) ? 32'h40 : (i == 7) ? 32'h11 : $urandom;
      step(d);
    end

    // Bypass: same-cycle write of r3, then a plain read of r3.
    d = instr_d(1, 3, 4); d.wb_en = 1'b1; d.wb_reg = 4'd3; d.wb_data = 32'hDEAD;
    step(d);
    d = instr_d(1, 3, 4); step(d);

    // Immediate, store data, return address.
    d = instr_d(1, 2, 3); d.imm_sel = 1'b1; d.imm = 32'd5; step(d);
    d = instr_d(7, 1, 2); d.st = 1'b1; step(d);
    d = instr_d(1, 2, 3); d.ret = 1'b1; step(d);

    // Load-use: ld r2, then dependent add held for one bubble.
    d = instr_d(2, 5, 6); d.ld = 1'b1; d.use1 = 1'b0; d.use2 = 1'b0; step(d);
    d = instr_d(4, 2, 6); d.use2 = 1'b0; step(d);
    step(d);

    // Flush beats hold and load-use.
    d = instr_d(2, 5, 6); d.ld = 1'b1; d.use1 = 1'b0; d.use2 = 1'b0; step(d);
    d = instr_d(4, 2, 6); d.flush = 1'b1; d.hold = 1'b1; step(d);
    d = idle(); step(d);

    // Hold for three cycles with changing D inputs, then release.
    d = instr_d(8, 9, 10); step(d);
    for (int i = 0; i < 3; i++) begin
      d = instr_d(i + 1, i + 2, i + 3); d.hold = 1'b1; step(d);
    end
    d = instr_d(11, 12, 13); step(d);

    // Reset in the middle of a load-use stall.
    d = instr_d(2, 5, 6); d.ld = 1'b1; d.use1 = 1'b0; d.use2 = 1'b0; step(d);
    d = instr_d(4, 2, 6); d.rst = 1'b1; step(d);
    d.rst = 1'b0; step(d);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) step(rnd());

    d = idle(); step(d);
    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
